// File: rtl/trainer_led_arbiter.sv
// trainer_led_arbiter: shares the 8 LEDs between a debounced DIP mirror and a CPU write port.
// Optional heartbeat on led[7] while the DIP mirror owns the LEDs: define TRAINER_LED_HEARTBEAT_EN.
module trainer_led_arbiter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int HB_DIV          = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] trainer_dip,
    input  logic       cpu_valid,
    input  logic [7:0] cpu_data,
    output logic       cpu_ready,
    input  logic       cpu_release,
    output logic [7:0] led,
    output logic       owner,
    output logic [7:0] dip_stable,
    output logic       dip_change
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);

    typedef enum logic {S_DIP = 1'b0, S_CPU = 1'b1} state_t;

    state_t        state, state_d;
    logic [7:0]    sync_a, sync_s, cand, led_d, dip_view;
    logic [DW-1:0] cnt;
    logic [HW-1:0] hold, hold_d;
    logic          wr, leave;

    assign wr    = cpu_valid & cpu_ready;
    assign leave = cpu_release | (hold == '0);
    assign owner = (state == S_CPU);

    // Ready comes up on the first clock out of reset and never drops.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cpu_ready <= 1'b0;
        else        cpu_ready <= 1'b1;

    // Two-flop synchroniser, then accept a candidate once it has been steady long enough.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync_a     <= '0;
            sync_s     <= '0;
            cand       <= '0;
            cnt        <= '0;
            dip_stable <= '0;
            dip_change <= 1'b0;
        end else begin
            sync_a     <= trainer_dip;
            sync_s     <= sync_a;
            cand       <= sync_s;
            cnt        <= (sync_s != cand) ? '0 : (cnt == D_MAX) ? cnt : cnt + DW'(1);
            dip_change <= (cnt == D_MAX) && (cand != dip_stable);
            if ((cnt == D_MAX) && (cand != dip_stable)) dip_stable <= cand;
        end

`ifdef TRAINER_LED_HEARTBEAT_EN
    localparam int BW = $clog2(HB_DIV + 1);
    localparam logic [BW-1:0] B_MAX = BW'(HB_DIV - 1);
    logic [BW-1:0] hb_cnt;
    logic          hb;

    // Free-running heartbeat, toggling every HB_DIV cycles.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else begin
            hb_cnt <= (hb_cnt == B_MAX) ? '0 : hb_cnt + BW'(1);
            hb     <= (hb_cnt == B_MAX) ? ~hb : hb;
        end

    assign dip_view = {hb, dip_stable[6:0]};
`else
    assign dip_view = dip_stable;
`endif

    // Ownership state, LED drive and hold timer registers.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_DIP;
            led   <= '0;
            hold  <= '0;
        end else begin
            state <= state_d;
            led   <= led_d;
            hold  <= hold_d;
        end

    // A write always claims the LEDs; the CPU otherwise keeps them until release or timeout.
    always_comb
        state_d = wr ? S_CPU : (state == S_CPU && !leave) ? S_CPU : S_DIP;

    // Write data wins, the DIP view shows whenever the mirror owns (or regains) the LEDs.
    always_comb begin
        led_d  = wr ? cpu_data : (state == S_DIP || leave) ? dip_view : led;
        hold_d = wr ? H_MAX : (state == S_CPU && hold != '0) ? hold - HW'(1) : hold;
    end
endmodule
